// File: rtl/instr_queue.sv
`default_nettype none
//==============================================================================
// instr_queue -- dual-issue circular instruction queue between fetch and decode
// Revision: 1.0
//==============================================================================
module instr_queue #(
  parameter int DEPTH = 16,
  parameter int IW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     enq_valid_1,
  input  logic                     enq_valid_2,
  input  logic [IW-1:0]            instr_enq_1,
  input  logic [IW-1:0]            pc_enq_1,
  input  logic [IW-1:0]            pre_pc_enq_1,
  input  logic                     pre_direction_enq_1,
  input  logic                     instr_is_compress_enq_1,
  input  logic [IW-1:0]            instr_enq_2,
  input  logic [IW-1:0]            pc_enq_2,
  input  logic [IW-1:0]            pre_pc_enq_2,
  input  logic                     pre_direction_enq_2,
  input  logic                     instr_is_compress_enq_2,
  output logic                     enq_ready,
  input  logic                     deq_ready,
  output logic                     deq_valid_1,
  output logic                     deq_valid_2,
  output logic [IW-1:0]            instr_deq_1,
  output logic [IW-1:0]            pc_deq_1,
  output logic [IW-1:0]            pre_pc_deq_1,
  output logic                     pre_direction_deq_1,
  output logic                     instr_is_compress_deq_1,
  output logic [IW-1:0]            instr_deq_2,
  output logic [IW-1:0]            pc_deq_2,
  output logic [IW-1:0]            pre_pc_deq_2,
  output logic                     pre_direction_deq_2,
  output logic                     instr_is_compress_deq_2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int              c_AW    = $clog2(DEPTH);
  localparam int              c_EW    = 3 * IW + 2;
  localparam logic [c_AW:0]   c_LIMIT = (c_AW + 1)'(DEPTH - 2);
  localparam logic [c_AW:0]   c_ONE   = (c_AW + 1)'(1);

  logic [c_EW-1:0] r_mem [DEPTH];
  logic [c_AW-1:0] r_head;
  logic [c_AW-1:0] r_tail;
  logic [c_AW:0]   r_count;

  logic            w_enq_ready;
  logic            w_deq_valid_1;
  logic            w_deq_valid_2;
  logic            w_enq_fire;
  logic            w_enq_two;
  logic [1:0]      w_enq_n;
  logic [1:0]      w_deq_n;
  logic [c_AW-1:0] w_head1;
  logic [c_AW-1:0] w_tail1;
  logic [c_EW-1:0] w_ent1;
  logic [c_EW-1:0] w_ent2;
  logic [c_EW-1:0] w_rd1;
  logic [c_EW-1:0] w_rd2;

  // Room is judged on current occupancy only; a same-cycle pop is not credited.
  assign w_enq_ready   = (r_count <= c_LIMIT);
  assign w_deq_valid_1 = (r_count != '0);
  assign w_deq_valid_2 = (r_count > c_ONE);

  // Slot 2 without slot 1 never fires, since slot 1 gates the whole enqueue.
  assign w_enq_fire = w_enq_ready & enq_valid_1 & ~flush;
  assign w_enq_two  = w_enq_fire & enq_valid_2;
  assign w_enq_n    = {w_enq_two, w_enq_fire & ~enq_valid_2};
  assign w_deq_n    = deq_ready ? {w_deq_valid_2, w_deq_valid_1 & ~w_deq_valid_2} : 2'b00;

  assign w_head1 = r_head + c_AW'(1);
  assign w_tail1 = r_tail + c_AW'(1);

  assign w_ent1 = {instr_enq_1, pc_enq_1, pre_pc_enq_1, pre_direction_enq_1, instr_is_compress_enq_1};
  assign w_ent2 = {instr_enq_2, pc_enq_2, pre_pc_enq_2, pre_direction_enq_2, instr_is_compress_enq_2};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_AW'(w_deq_n);
      r_tail  <= r_tail + c_AW'(w_enq_n);
      r_count <= r_count + (c_AW + 1)'(w_enq_n) - (c_AW + 1)'(w_deq_n);
    end
  end

  // Entry storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (w_enq_fire) begin
      r_mem[r_tail] <= w_ent1;
      if (w_enq_two) begin
        r_mem[w_tail1] <= w_ent2;
      end
    end
  end

  assign w_rd1 = r_mem[r_head];
  assign w_rd2 = r_mem[w_head1];

  assign {instr_deq_1, pc_deq_1, pre_pc_deq_1, pre_direction_deq_1, instr_is_compress_deq_1} = w_rd1;
  assign {instr_deq_2, pc_deq_2, pre_pc_deq_2, pre_direction_deq_2, instr_is_compress_deq_2} = w_rd2;

  assign enq_ready   = w_enq_ready;
  assign deq_valid_1 = w_deq_valid_1;
  assign deq_valid_2 = w_deq_valid_2;
  assign count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_queue.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// tb_instr_queue -- directed and random checks against a queue-based model
// Revision: 1.0
//==============================================================================
module tb_instr_queue;

  localparam int DEPTH = 16;
  localparam int IW    = 32;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [IW-1:0] pc;
    logic [IW-1:0] ppc;
    logic          dir;
    logic          rvc;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic flush = 1'b0;
  logic enq_valid_1 = 1'b0, enq_valid_2 = 1'b0, deq_ready = 1'b0;
  logic [IW-1:0] instr_enq_1 = '0, pc_enq_1 = '0, pre_pc_enq_1 = '0;
  logic [IW-1:0] instr_enq_2 = '0, pc_enq_2 = '0, pre_pc_enq_2 = '0;
  logic pre_direction_enq_1 = 1'b0, instr_is_compress_enq_1 = 1'b0;
  logic pre_direction_enq_2 = 1'b0, instr_is_compress_enq_2 = 1'b0;
  logic enq_ready, deq_valid_1, deq_valid_2;
  logic [IW-1:0] instr_deq_1, pc_deq_1, pre_pc_deq_1;
  logic [IW-1:0] instr_deq_2, pc_deq_2, pre_pc_deq_2;
  logic pre_direction_deq_1, instr_is_compress_deq_1;
  logic pre_direction_deq_2, instr_is_compress_deq_2;
  logic [$clog2(DEPTH):0] count;

  int   n_chk = 0;
  int   n_fail = 0;
  logic [IW-1:0] next_pc = 32'h100;
  ent_t mq[$];

  instr_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .enq_valid_1(enq_valid_1), .enq_valid_2(enq_valid_2),
    .instr_enq_1(instr_enq_1), .pc_enq_1(pc_enq_1), .pre_pc_enq_1(pre_pc_enq_1),
    .pre_direction_enq_1(pre_direction_enq_1), .instr_is_compress_enq_1(instr_is_compress_enq_1),
    .instr_enq_2(instr_enq_2), .pc_enq_2(pc_enq_2), .pre_pc_enq_2(pre_pc_enq_2),
    .pre_direction_enq_2(pre_direction_enq_2), .instr_is_compress_enq_2(instr_is_compress_enq_2),
    .enq_ready(enq_ready), .deq_ready(deq_ready),
    .deq_valid_1(deq_valid_1), .deq_valid_2(deq_valid_2),
    .instr_deq_1(instr_deq_1), .pc_deq_1(pc_deq_1), .pre_pc_deq_1(pre_pc_deq_1),
    .pre_direction_deq_1(pre_direction_deq_1), .instr_is_compress_deq_1(instr_is_compress_deq_1),
    .instr_deq_2(instr_deq_2), .pc_deq_2(pc_deq_2), .pre_pc_deq_2(pre_pc_deq_2),
    .pre_direction_deq_2(pre_direction_deq_2), .instr_is_compress_deq_2(instr_is_compress_deq_2),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t mk();
    ent_t e;
    e.instr = $urandom;
    e.pc    = next_pc;
    e.ppc   = $urandom;
    e.dir   = 1'($urandom);
    e.rvc   = 1'($urandom);
    next_pc = next_pc + 32'd4;
    return e;
  endfunction

  // Compare every visible output against the model's occupancy and head entries.
  task automatic check_state();
    int sz;
    sz = mq.size();
    chk("count", IW'(count), IW'(sz));
    chk("no_overflow", IW'(count <= DEPTH), 32'd1);
    chk("deq_valid_1", IW'(deq_valid_1), IW'(sz >= 1));
    chk("deq_valid_2", IW'(deq_valid_2), IW'(sz >= 2));
    chk("enq_ready", IW'(enq_ready), IW'(DEPTH - sz >= 2));
    if (sz >= 1) begin
      chk("pc_deq_1", pc_deq_1, mq[0].pc);
      chk("instr_deq_1", instr_deq_1, mq[0].instr);
      chk("pre_pc_deq_1", pre_pc_deq_1, mq[0].ppc);
      chk("flags_deq_1", IW'({pre_direction_deq_1, instr_is_compress_deq_1}), IW'({mq[0].dir, mq[0].rvc}));
    end
    if (sz >= 2) begin
      chk("pc_deq_2", pc_deq_2, mq[1].pc);
      chk("instr_deq_2", instr_deq_2, mq[1].instr);
      chk("pre_pc_deq_2", pre_pc_deq_2, mq[1].ppc);
      chk("flags_deq_2", IW'({pre_direction_deq_2, instr_is_compress_deq_2}), IW'({mq[1].dir, mq[1].rvc}));
    end
  endtask

  // One clock: check, drive, clock, update the model, return at edge + 1.
  task automatic cycle(input logic v1, input logic v2, input logic dr, input logic fl);
    ent_t a;
    ent_t b;
    int   sz;
    check_state();
    a = mk();
    b = mk();
    enq_valid_1 = v1; enq_valid_2 = v2; deq_ready = dr; flush = fl;
    instr_enq_1 = a.instr; pc_enq_1 = a.pc; pre_pc_enq_1 = a.ppc;
    pre_direction_enq_1 = a.dir; instr_is_compress_enq_1 = a.rvc;
    instr_enq_2 = b.instr; pc_enq_2 = b.pc; pre_pc_enq_2 = b.ppc;
    pre_direction_enq_2 = b.dir; instr_is_compress_enq_2 = b.rvc;
    @(posedge clk);
    sz = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      if (dr) repeat ((sz >= 2) ? 2 : sz) void'(mq.pop_front());
      if (v1 && (DEPTH - sz >= 2)) begin
        mq.push_back(a);
        if (v2) mq.push_back(b);
      end
    end
    #1;
    enq_valid_1 = 1'b0; enq_valid_2 = 1'b0; deq_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    // Reset state while reset is held low
    #1;
    chk("rst_count", IW'(count), 32'd0);
    chk("rst_deq_valid_1", IW'(deq_valid_1), 32'd0);
    chk("rst_deq_valid_2", IW'(deq_valid_2), 32'd0);
    chk("rst_enq_ready", IW'(enq_ready), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // One pair with PCs 0x100 / 0x104
    next_pc = 32'h100;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pair_pc1", pc_deq_1, 32'h100);
    chk("pair_pc2", pc_deq_2, 32'h104);
    chk("pair_count", IW'(count), 32'd2);

    // Fill to 14, then 16, then an ignored single
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("fill14_count", IW'(count), 32'd14);
    chk("fill14_ready", IW'(enq_ready), 32'd1);
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("fill16_count", IW'(count), 32'd16);
    chk("fill16_ready", IW'(enq_ready), 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("full_ignore", IW'(count), 32'd16);

    // Count 15, pop two, push one, drain in order
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (7) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("fill15_count", IW'(count), 32'd15);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pop_count13", IW'(count), 32'd13);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("push_count14", IW'(count), 32'd14);
    repeat (8) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("drained", IW'(count), 32'd0);

    // Illegal slot-2-only enqueue writes nothing
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    chk("illegal_v2", IW'(count), 32'd0);

    // 40 singles with dequeue every other cycle; pointers wrap repeatedly
    for (int i = 0; i < 40; i++) cycle(1'b1, 1'b0, 1'(i % 2), 1'b0);
    repeat (25) cycle(1'b0, 1'b0, 1'b1, 1'b0);
    chk("stream_drained", IW'(count), 32'd0);

    // Flush beats simultaneous enqueue and dequeue
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    chk("pre_flush6", IW'(count), 32'd6);
    cycle(1'b1, 1'b1, 1'b1, 1'b1);
    chk("flush_count", IW'(count), 32'd0);
    chk("flush_valid1", IW'(deq_valid_1), 32'd0);
    chk("flush_ready", IW'(enq_ready), 32'd1);

    // Asynchronous reset between edges at count 9
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    chk("pre_reset9", IW'(count), 32'd9);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_count", IW'(count), 32'd0);
    chk("async_rst_valid1", IW'(deq_valid_1), 32'd0);
    mq.delete();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Random traffic, including occasional flushes
    for (int i = 0; i < 400; i++) begin
      logic v1;
      v1 = 1'($urandom);
      cycle(v1, v1 & 1'($urandom), 1'($urandom_range(0, 2) == 0 ? 0 : $urandom), 1'($urandom_range(0, 31) == 0));
    end
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
